// File: rtl/axi_stream_extract_header.sv
// Strips a configurable number of leading header bytes from each packet and repacks the payload MSB-aligned.
// Define AXIS_EXTRACT_HDR_OUT_EN to present the stripped header on the header port; otherwise it is discarded.
//
// state | meaning
// IDLE  | waiting for the per-packet byte count on the cfg port
// HDR   | waiting for the first beat, which carries the header bytes
// BODY  | repacking the remaining beats of the packet
// FLUSH | emitting the residual beat left over after the last input beat
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic                    last_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic                    last_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    valid_header,
  input  logic                    ready_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    valid_cfg,
  output logic                    ready_cfg,
  input  logic [BYTE_CNT_WD:0]    byte_extract_cnt
);

  localparam int CW = BYTE_CNT_WD + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, HDR, BODY, FLUSH} state_t;

  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CW:0] n);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[DATA_BYTE_WD-1-i] = ((CW+1)'(i) < n);
    return m;
  endfunction

  function automatic logic [CW-1:0] ones_cnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CW'(k[i]);
    return c;
  endfunction

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q;
  logic [DATA_WD-1:0]       carry_q, carry_d;
  logic [CW-1:0]            carry_cnt_q, carry_cnt_d;
  logic                     hdr_busy;
  logic                     slot_free, in_fire;
  logic [CW-1:0]            kc, drop, new_cnt;
  logic [DATA_WD-1:0]       data_m, new_al;
  logic [2*DATA_WD-1:0]     cat;
  logic [CW:0]              total;
  logic                     emit, emit_last;
  logic [DATA_WD-1:0]       emit_data;
  logic [DATA_BYTE_WD-1:0]  emit_keep;

  assign slot_free = !valid_out || ready_out;
  assign ready_in  = ((state_q == HDR) || (state_q == BODY)) && slot_free;
  assign ready_cfg = (state_q == IDLE) && !hdr_busy;
  assign in_fire   = valid_in && ready_in;

  // New bytes are appended directly behind the carried bytes in a double-width window;
  // the upper half is the candidate output beat, the lower half the next carry.
  always_comb begin
    data_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++)
      data_m[8*i +: 8] = keep_in[i] ? data_in[8*i +: 8] : 8'h00;
    kc      = ones_cnt(keep_in);
    drop    = (state_q == HDR) ? cnt_q : '0;
    new_cnt = (kc > drop) ? kc - drop : '0;
    new_al  = data_m << {drop, 3'b000};
    cat     = {carry_q, {DATA_WD{1'b0}}} | ({new_al, {DATA_WD{1'b0}}} >> {carry_cnt_q, 3'b000});
    total   = {1'b0, carry_cnt_q} + {1'b0, new_cnt};
  end

  always_comb begin
    state_d     = state_q;
    carry_d     = carry_q;
    carry_cnt_d = carry_cnt_q;
    emit        = 1'b0;
    emit_data   = cat[2*DATA_WD-1 -: DATA_WD];
    emit_keep   = '1;
    emit_last   = 1'b0;
    case (state_q)
      IDLE: begin
        carry_d     = '0;
        carry_cnt_d = '0;
        if (valid_cfg && ready_cfg) state_d = HDR;
      end
      HDR, BODY: begin
        if (in_fire) begin
          state_d = BODY;
          if (total >= FULL) begin
            emit        = 1'b1;
            carry_d     = cat[DATA_WD-1:0];
            carry_cnt_d = CW'(total - FULL);
            if (last_in) begin
              if (total == FULL) begin
                emit_last = 1'b1;
                state_d   = IDLE;
              end else begin
                state_d = FLUSH;
              end
            end
          end else begin
            carry_d     = cat[2*DATA_WD-1 -: DATA_WD];
            carry_cnt_d = CW'(total);
            if (last_in) begin
              emit      = (total != '0);
              emit_keep = top_mask(total);
              emit_last = 1'b1;
              state_d   = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        emit_data = carry_q;
        emit_keep = top_mask({1'b0, carry_cnt_q});
        emit_last = 1'b1;
        // The residual is loaded once; afterwards wait for its last_out handshake.
        if (slot_free && !(valid_out && last_out)) emit = 1'b1;
        if (valid_out && last_out && ready_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= '0;
      carry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      carry_cnt_q <= carry_cnt_d;
      if (valid_cfg && ready_cfg) cnt_q <= byte_extract_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
    end else if (emit) begin
      valid_out <= 1'b1;
      last_out  <= emit_last;
      data_out  <= emit_data;
      keep_out  <= emit_keep;
    end else if (ready_out) begin
      valid_out <= 1'b0;
      last_out  <= 1'b0;
    end
  end

`ifdef AXIS_EXTRACT_HDR_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_header <= 1'b0;
      data_header  <= '0;
      keep_header  <= '0;
    end else if ((state_q == HDR) && in_fire && (cnt_q != '0)) begin
      valid_header <= 1'b1;
      data_header  <= data_in;
      keep_header  <= keep_in & top_mask({1'b0, cnt_q});
    end else if (ready_header) begin
      valid_header <= 1'b0;
    end
  end
  assign hdr_busy = valid_header;
`else
  logic unused_hdr;
  assign unused_hdr   = ready_header;
  assign valid_header = 1'b0;
  assign data_header  = '0;
  assign keep_header  = '0;
  assign hdr_busy     = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// Bench for axi_stream_extract_header: directed vector table, random packets against a byte-queue
// model with backpressure, hold-stability monitoring and an asynchronous mid-packet reset.
module tb_axi_stream_extract_header;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int NV = 7;
`ifdef AXIS_EXTRACT_HDR_OUT_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0, ready_in, last_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [BW-1:0] keep_in = '0;
  logic          valid_out, ready_out = 1'b1, last_out;
  logic [DW-1:0] data_out;
  logic [BW-1:0] keep_out;
  logic          valid_header, ready_header = 1'b1;
  logic [DW-1:0] data_header;
  logic [BW-1:0] keep_header;
  logic          valid_cfg = 1'b0, ready_cfg;
  logic [2:0]    byte_extract_cnt = '0;

  int checks = 0;
  int failures = 0;
  int bp_mode = 0;

  always #5 clk = ~clk;

  axi_stream_extract_header #(.DATA_WD(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .ready_in(ready_in), .last_in(last_in),
    .data_in(data_in), .keep_in(keep_in),
    .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
    .data_out(data_out), .keep_out(keep_out),
    .valid_header(valid_header), .ready_header(ready_header),
    .data_header(data_header), .keep_header(keep_header),
    .valid_cfg(valid_cfg), .ready_cfg(ready_cfg),
    .byte_extract_cnt(byte_extract_cnt)
  );

  typedef struct packed { logic [31:0] d; logic [3:0] k; logic l; } beat_t;
  typedef struct packed { logic [31:0] d; logic [3:0] k; } hdr_t;
  beat_t exp_pay_q[$];
  hdr_t  exp_hdr_q[$];

  typedef struct {
    int cnt; int nb;
    logic [2:0][31:0] d; logic [2:0][3:0] k;
    bit hv; logic [31:0] hd; logic [3:0] hk;
    int np;
    logic [2:0][31:0] pd; logic [2:0][3:0] pk;
  } vec_t;
  vec_t vecs[NV];

  logic [31:0] pkt_d[8];
  logic [3:0]  pkt_k[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  // Handshakes complete at the next posedge; inputs only change at posedge+1, so negedge values are stable.
  logic [37:0] prev_pay;
  logic [36:0] prev_hdr;
  bit pv_stall = 0, hv_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv_stall = 0;
      hv_stall = 0;
    end else begin
      if (pv_stall) check("payload_hold", {valid_out, data_out, keep_out, last_out}, prev_pay);
      if (hv_stall) check("header_hold", {valid_header, data_header, keep_header}, prev_hdr);
      if (valid_out && ready_out) begin
        if (exp_pay_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_payload actual=%0h required=none", {data_out, keep_out, last_out});
        end else begin
          check("payload", {data_out, keep_out, last_out}, exp_pay_q.pop_front());
        end
      end
      if (valid_header && ready_header) begin
        if (exp_hdr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_header actual=%0h required=none", {data_header, keep_header});
        end else begin
          check("header", {data_header, keep_header}, exp_hdr_q.pop_front());
        end
      end
      pv_stall = valid_out && !ready_out;
      hv_stall = valid_header && !ready_header;
      prev_pay = {valid_out, data_out, keep_out, last_out};
      prev_hdr = {valid_header, data_header, keep_header};
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0: begin ready_out = 1'b1; ready_header = 1'b1; end
        1: begin ready_out = ($urandom_range(0, 3) != 0); ready_header = ($urandom_range(0, 2) != 0); end
        default: begin ready_out = 1'b0; ready_header = 1'b0; end
      endcase
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // Reference: flatten the packet into a byte queue, strip the header bytes, regroup by beat width.
  task automatic model_packet(input int cnt, input int nb);
    logic [7:0] q[$];
    int kc, drop;
    beat_t b;
    logic [3:0] m;
    drop = 0;
    for (int i = 0; i < nb; i++) begin
      kc = $countones(pkt_k[i]);
      for (int j = 0; j < kc; j++) q.push_back(pkt_d[i][31-8*j -: 8]);
      if (i == 0) drop = (cnt < kc) ? cnt : kc;
    end
    for (int j = 0; j < drop; j++) q.delete(0);
    while (q.size() > 0) begin
      b = '0;
      for (int j = 0; j < 4 && q.size() > 0; j++) begin
        b.d[31-8*j -: 8] = q.pop_front();
        b.k[3-j] = 1'b1;
      end
      b.l = (q.size() == 0);
      exp_pay_q.push_back(b);
    end
    if (HDR_EN && cnt > 0) begin
      m = 4'hF;
      m = m << (4 - cnt);
      exp_hdr_q.push_back({pkt_d[0], pkt_k[0] & m});
    end
  endtask

  task automatic do_cfg(input int c);
    int t;
    bit f;
    t = 0;
    valid_cfg = 1'b1;
    byte_extract_cnt = 3'(c);
    forever begin
      @(negedge clk); f = ready_cfg;
      @(posedge clk); #1;
      if (f) break;
      t++;
      if (t > 2000) begin fail_event("cfg_wait"); break; end
    end
    valid_cfg = 1'b0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t;
    bit f;
    t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    forever begin
      @(negedge clk); f = ready_in;
      @(posedge clk); #1;
      if (f) break;
      t++;
      if (t > 2000) begin fail_event("beat_wait"); break; end
    end
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_pay_q.size() != 0 || exp_hdr_q.size() != 0) && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 3000) begin
      fail_event(name);
      exp_pay_q.delete();
      exp_hdr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic set_vec(input int i, input int cnt, input int nb,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                         input bit hv, input logic [31:0] hd, input logic [3:0] hk, input int np,
                         input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [3:0] q0, input logic [3:0] q1, input logic [3:0] q2);
    vecs[i].cnt = cnt; vecs[i].nb = nb;
    vecs[i].d[0] = d0; vecs[i].d[1] = d1; vecs[i].d[2] = d2;
    vecs[i].k[0] = k0; vecs[i].k[1] = k1; vecs[i].k[2] = k2;
    vecs[i].hv = hv; vecs[i].hd = hd; vecs[i].hk = hk; vecs[i].np = np;
    vecs[i].pd[0] = p0; vecs[i].pd[1] = p1; vecs[i].pd[2] = p2;
    vecs[i].pk[0] = q0; vecs[i].pk[1] = q1; vecs[i].pk[2] = q2;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    for (int p = 0; p < v.np; p++) exp_pay_q.push_back({v.pd[p], v.pk[p], (p == v.np - 1)});
    if (HDR_EN && v.hv) exp_hdr_q.push_back({v.hd, v.hk});
    do_cfg(v.cnt);
    for (int b = 0; b < v.nb; b++) begin
      drive_beat(v.d[b], v.k[b], (b == v.nb - 1));
      if (v.cnt == 0) check($sformatf("latency_v%0d_b%0d", i, b), {valid_out, data_out}, {1'b1, v.pd[b]});
    end
    wait_drain($sformatf("drain_v%0d", i));
    check($sformatf("idle_v%0d", i), ready_cfg, 1);
  endtask

  initial begin
    int cnt, nb;
    logic [3:0] lk;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {valid_out, last_out, valid_header, ready_in}, 0);
    check("rst_payload", {data_out, keep_out}, 0);
    check("rst_header", {data_header, keep_header}, 0);
    rst_n = 1'b1;
    #1;
    check("rst_release_cfg", {ready_cfg, ready_in}, 2'b10);

    set_vec(0, 1, 3, 32'hAABBCCDD, 32'h11223344, 32'h55667788, 4'hF, 4'hF, 4'hC,
            1, 32'hAABBCCDD, 4'h8, 3, 32'hBBCCDD11, 32'h22334455, 32'h66000000, 4'hF, 4'hF, 4'h8);
    set_vec(1, 1, 2, 32'hAABBCCDD, 32'h11223344, 32'h0, 4'hF, 4'hF, 4'h0,
            1, 32'hAABBCCDD, 4'h8, 2, 32'hBBCCDD11, 32'h22334400, 32'h0, 4'hF, 4'hE, 4'h0);
    set_vec(2, 0, 2, 32'h01020304, 32'h05060708, 32'h0, 4'hF, 4'hC, 4'h0,
            0, 32'h0, 4'h0, 2, 32'h01020304, 32'h05060000, 32'h0, 4'hF, 4'hC, 4'h0);
    set_vec(3, 4, 1, 32'hDEADBEEF, 32'h0, 32'h0, 4'hF, 4'h0, 4'h0,
            1, 32'hDEADBEEF, 4'hF, 0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);
    set_vec(4, 2, 1, 32'h12345678, 32'h0, 32'h0, 4'hE, 4'h0, 4'h0,
            1, 32'h12345678, 4'hC, 1, 32'h56000000, 32'h0, 32'h0, 4'h8, 4'h0, 4'h0);
    set_vec(5, 3, 2, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'h0, 4'hF, 4'h8, 4'h0,
            1, 32'hA1A2A3A4, 4'hE, 1, 32'hA4B10000, 32'h0, 32'h0, 4'hC, 4'h0, 4'h0);
    set_vec(6, 2, 1, 32'h77665544, 32'h0, 32'h0, 4'h8, 4'h0, 4'h0,
            1, 32'h77665544, 4'h8, 0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < NV; i++) run_vec(i);

    bp_mode = 1;
    for (int p = 0; p < 150; p++) begin
      cnt = $urandom_range(0, 4);
      nb  = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        pkt_d[b] = $urandom;
        pkt_k[b] = 4'hF;
      end
      lk = 4'hF;
      lk = lk << $urandom_range(0, 3);
      pkt_k[nb-1] = lk;
      model_packet(cnt, nb);
      do_cfg(cnt);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drive_beat(pkt_d[b], pkt_k[b], (b == nb - 1));
      end
    end
    wait_drain("drain_random");

    // Mid-packet reset with both sinks stalled, so the partial packet never handshakes.
    bp_mode = 2;
    @(posedge clk); #1;
    do_cfg(1);
    drive_beat(32'hAABBCCDD, 4'hF, 1'b0);
    drive_beat(32'h11223344, 4'hF, 1'b0);
    check("pre_reset_valid_out", valid_out, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {valid_out, last_out, valid_header, ready_in}, 0);
    check("midrst_payload", {data_out, keep_out}, 0);
    check("midrst_header", {data_header, keep_header}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("midrst_release_cfg", {ready_cfg, ready_in}, 2'b10);
    bp_mode = 0;
    @(posedge clk); #1;
    run_vec(0);
    run_vec(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
